// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_dot_sequencer
// Description : Drives one int8 MAC lane (built with LAST_SUM_W=0) through a
//               signed dot product of programmable length. Operand pairs
//               arrive on a valid/ready stream; the MAC double-buffered weight
//               strobes are skewed preload -> load -> enable over three
//               cycles, and MAC products are summed into a SUM_W accumulator
//               returned on a valid/ready result port.
//               Optional build macro: MAC_SEQ_SAT_EN (saturating accumulate
//               with a sticky res_sat flag; otherwise the sum wraps and
//               res_sat is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module mac_dot_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int SUM_W  = 32,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic [DATA_W-1:0] in_w,
  input  logic [DATA_W-1:0] in_x,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] mac_weight_in,
  output logic              mac_preload,
  output logic              mac_load,
  output logic              mac_enable,
  output logic [DATA_W-1:0] mac_input_val,
  input  logic [ACC_W-1:0]  mac_out,
  input  logic              mac_out_valid,
  output logic [SUM_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_sat
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  res_cnt_q, res_cnt_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;

  // Two-deep delay line carrying the accept strobe and x operand to the
  // load (t+1) and enable (t+2) slots of the MAC.
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;

  logic              accept;
  logic [LEN_W-1:0]  issue_cnt_inc;
  logic [LEN_W-1:0]  res_cnt_inc;
  logic [SUM_W-1:0]  prod_ext;
  logic [SUM_W-1:0]  acc_add;
  logic              add_clamp;

  assign in_ready      = (state_q == ST_RUN) && (issue_cnt_q < len_q);
  assign accept        = in_valid & in_ready;
  assign issue_cnt_inc = issue_cnt_q + 1'b1;
  assign res_cnt_inc   = res_cnt_q + 1'b1;
  assign prod_ext      = SUM_W'($signed(mac_out));

`ifdef MAC_SEQ_SAT_EN
  localparam logic [SUM_W-1:0] C_SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] C_SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  // One guard bit exposes signed overflow: the top two bits disagree.
  logic [SUM_W:0] sum_wide;
  logic           ovf;

  assign sum_wide  = {acc_q[SUM_W-1], acc_q} + {prod_ext[SUM_W-1], prod_ext};
  assign ovf       = sum_wide[SUM_W] ^ sum_wide[SUM_W-1];
  assign acc_add   = !ovf ? sum_wide[SUM_W-1:0]
                          : (sum_wide[SUM_W] ? C_SUM_MIN : C_SUM_MAX);
  assign add_clamp = ovf;
`else
  assign acc_add   = acc_q + prod_ext;
  assign add_clamp = 1'b0;
`endif

  // Next-state logic for the job FSM, counters and accumulator.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    acc_d       = acc_q;
    sat_d       = sat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = len;
          issue_cnt_d = '0;
          res_cnt_d   = '0;
          acc_d       = '0;
          sat_d       = 1'b0;
          state_d     = (len == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (accept) begin
          issue_cnt_d = issue_cnt_inc;
          if (issue_cnt_inc == len_q) begin
            state_d = ST_DRAIN;
          end
        end
        if (mac_out_valid) begin
          acc_d     = acc_add;
          sat_d     = sat_q | add_clamp;
          res_cnt_d = res_cnt_inc;
          // The final product is added in the same cycle the count completes.
          if ((state_q == ST_DRAIN) && (res_cnt_inc == len_q)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe skew: what is accepted now is loaded next cycle, enabled after.
  always_comb begin
    v1_d = accept;
    x1_d = accept ? in_x : '0;
    v2_d = v1_q;
    x2_d = x1_q;
  end

  // State, counter, accumulator and delay-line registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      x1_q        <= '0;
      x2_q        <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
    end
  end

  // Weight is forced to 0 outside accept cycles so idle strobes stay quiet.
  assign mac_preload   = accept;
  assign mac_weight_in = accept ? in_w : '0;
  assign mac_load      = v1_q;
  assign mac_enable    = v2_q;
  assign mac_input_val = x2_q;

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_valid ? acc_q : '0;
  assign res_sat   = res_valid & sat_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mac_dot_sequencer
// Description : Self-checking bench. Two sequencers (SUM_W=32 and SUM_W=16)
//               share one operand/result stimulus stream; each drives its own
//               behavioural MAC lane. Results are compared with a table of
//               constants and with an arithmetic dot-product model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_dot_sequencer;

  localparam int LEN_W = 10;
`ifdef MAC_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int     n;
    int     gap;
    int     stall;
    int     w [4];
    int     x [4];
    longint e32;
    longint e16;
    bit     es16;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, in_valid, res_ready, spur;
  logic [LEN_W-1:0] len;
  logic [7:0] in_w, in_x;
  logic [1:0] busy, in_ready, mac_preload, mac_load, mac_enable;
  logic [1:0] mac_out_valid, res_valid, res_sat;
  logic [1:0][7:0]  mac_weight_in, mac_input_val;
  logic [1:0][15:0] mac_out;
  logic [31:0] res_data32;
  logic [15:0] res_data16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cnt [2];
  logic [7:0] pw [64];
  logic [7:0] px [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_sequencer #(.DATA_W(8), .ACC_W(16), .SUM_W(32), .LEN_W(LEN_W)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy[0]),
    .in_w(in_w), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready[0]),
    .mac_weight_in(mac_weight_in[0]), .mac_preload(mac_preload[0]),
    .mac_load(mac_load[0]), .mac_enable(mac_enable[0]),
    .mac_input_val(mac_input_val[0]), .mac_out(mac_out[0]),
    .mac_out_valid(mac_out_valid[0]), .res_data(res_data32),
    .res_valid(res_valid[0]), .res_ready(res_ready), .res_sat(res_sat[0])
  );

  mac_dot_sequencer #(.DATA_W(8), .ACC_W(16), .SUM_W(16), .LEN_W(LEN_W)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy[1]),
    .in_w(in_w), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready[1]),
    .mac_weight_in(mac_weight_in[1]), .mac_preload(mac_preload[1]),
    .mac_load(mac_load[1]), .mac_enable(mac_enable[1]),
    .mac_input_val(mac_input_val[1]), .mac_out(mac_out[1]),
    .mac_out_valid(mac_out_valid[1]), .res_data(res_data16),
    .res_valid(res_valid[1]), .res_ready(res_ready), .res_sat(res_sat[1])
  );

  // ---------------- behavioural MAC lanes (3-cycle product latency) --------
  logic [1:0][7:0]       m_pre, m_act;
  logic [1:0][2:0][15:0] m_p;
  logic [1:0][2:0]       m_v;

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return 16'(ia * ib);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pre <= '0; m_act <= '0; m_p <= '0; m_v <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mac_preload[i]) m_pre[i] <= mac_weight_in[i];
        if (mac_load[i])    m_act[i] <= m_pre[i];
        m_p[i][0] <= mac_enable[i] ? mul8(m_act[i], mac_input_val[i]) : 16'h0;
        m_v[i][0] <= mac_enable[i];
        m_p[i][1] <= m_p[i][0]; m_v[i][1] <= m_v[i][0];
        m_p[i][2] <= m_p[i][1]; m_v[i][2] <= m_v[i][1];
      end
    end
  end

  // spur injects a bogus product that must be ignored outside RUN/DRAIN
  assign mac_out_valid[0] = m_v[0][2] | spur;
  assign mac_out_valid[1] = m_v[1][2] | spur;
  assign mac_out[0]       = spur ? 16'd100 : m_p[0][2];
  assign mac_out[1]       = spur ? 16'd100 : m_p[1][2];

  // ---------------- checking helpers ----------------------------------------
  function automatic void chk(input bit ok, input string nm,
                              input longint act, input longint req);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic bit outs_zero();
    return (busy == 2'b00) && (in_ready == 2'b00) && (mac_preload == 2'b00) &&
           (mac_load == 2'b00) && (mac_enable == 2'b00) && (res_valid == 2'b00) &&
           (res_sat == 2'b00) && (res_data32 == 32'h0) && (res_data16 == 16'h0) &&
           (mac_weight_in == '0) && (mac_input_val == '0);
  endfunction

  // Dot product by plain arithmetic: wrap or clamp after every term.
  function automatic longint model(input int n, input int sw, input bit sat,
                                   output bit clamped);
    longint s, lo, hi, m;
    clamped = 1'b0;
    s  = 0;
    m  = longint'(1) << sw;
    hi = (longint'(1) << (sw - 1)) - 1;
    lo = -(longint'(1) << (sw - 1));
    for (int k = 0; k < n; k++) begin
      s = s + longint'($signed(pw[k])) * longint'($signed(px[k]));
      if (sat) begin
        if (s > hi) begin s = hi; clamped = 1'b1; end
        else if (s < lo) begin s = lo; clamped = 1'b1; end
      end else begin
        if (s > hi) s = s - m;
        else if (s < lo) s = s + m;
      end
    end
    return s;
  endfunction

  // Cycle-by-cycle strobe skew check against the observed accepts.
  logic [1:0]      h_v1 = '0, h_v2 = '0;
  logic [1:0][7:0] h_x1 = '0, h_x2 = '0;
  always @(negedge clk) begin
    if (reset) begin
      h_v1 = '0; h_v2 = '0; h_x1 = '0; h_x2 = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic a;
        a = in_valid & in_ready[i];
        chk({mac_preload[i], mac_load[i], mac_enable[i]} == {a, h_v1[i], h_v2[i]},
            $sformatf("strobes_lane%0d", i),
            {mac_preload[i], mac_load[i], mac_enable[i]}, {a, h_v1[i], h_v2[i]});
        if (a) chk(mac_weight_in[i] == in_w, $sformatf("weight_in_lane%0d", i),
                   mac_weight_in[i], in_w);
        if (h_v2[i]) chk(mac_input_val[i] == h_x2[i], $sformatf("input_val_lane%0d", i),
                         mac_input_val[i], h_x2[i]);
        if (mac_enable[i]) en_cnt[i] = en_cnt[i] + 1;
        h_v2[i] = h_v1[i]; h_x2[i] = h_x1[i];
        h_v1[i] = a;       h_x1[i] = in_x;
      end
    end
  end

  // ---------------- job driver ----------------------------------------------
  // gap: 0 = back-to-back, 1 = valid on alternate cycles, 2 = random gaps.
  task automatic run_job(input string nm, input int n, input int gap, input int stall,
                         input longint e32, input longint e16, input bit es16);
    int k, guard, t_first, t_start, t_res, en0, en1;
    en0 = en_cnt[0];
    en1 = en_cnt[1];
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(n);
    @(negedge clk); t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0; len = '0;
    k = 0; guard = 0; t_first = -1;
    while (k < n && guard < 400) begin
      in_valid = (gap == 0) || (gap == 1 && (guard % 2 == 0)) ||
                 (gap == 2 && $urandom_range(0, 2) != 0);
      in_w = pw[k]; in_x = px[k];
      @(negedge clk);
      if (in_valid && in_ready[0]) begin
        if (k == 0) t_first = cyc;
        k = k + 1;
      end
      @(posedge clk); #1;
      guard = guard + 1;
    end
    in_valid = 1'b0; in_w = 8'($urandom); in_x = 8'($urandom);
    chk(k == n, {nm, "_pairs_accepted"}, k, n);
    @(negedge clk);
    chk(in_ready == 2'b00, {nm, "_in_ready_drop"}, in_ready, 0);
    guard = 0;
    while (res_valid[0] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard = guard + 1;
    end
    t_res = cyc;
    chk(res_valid == 2'b11, {nm, "_res_valid"}, res_valid, 3);
    if (n == 0)
      chk(t_res == t_start + 1, {nm, "_latency"}, t_res - t_start, 1);
    else if (gap == 0)
      chk(t_res == t_first + n + 5, {nm, "_latency"}, t_res - t_first, n + 5);
    chk(res_data32 == 32'(e32), {nm, "_res32"}, $signed(res_data32), e32);
    chk(res_data16 == 16'(e16), {nm, "_res16"}, $signed(res_data16), e16);
    chk(res_sat == {es16, 1'b0}, {nm, "_res_sat"}, res_sat, {es16, 1'b0});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      start = (s % 3 == 0); len = 10'd5; spur = (s == 1);
      @(negedge clk);
      chk(res_valid == 2'b11 && res_data32 == 32'(e32) && res_data16 == 16'(e16) &&
          res_sat == {es16, 1'b0}, {nm, "_stall_hold"}, $signed(res_data32), e32);
    end
    @(posedge clk); #1;
    spur = 1'b0; start = (stall > 0); len = 10'd5; res_ready = 1'b1;
    @(negedge clk);
    chk(res_valid == 2'b11 && res_data32 == 32'(e32) && res_data16 == 16'(e16),
        {nm, "_handshake"}, $signed(res_data32), e32);
    @(posedge clk); #1;
    start = 1'b0; len = '0; res_ready = 1'b0;
    @(negedge clk);
    chk(res_valid == 2'b00 && busy == 2'b00, {nm, "_back_to_idle"}, {res_valid, busy}, 0);
    chk(en_cnt[0] - en0 == n && en_cnt[1] - en1 == n, {nm, "_enable_count"},
        en_cnt[0] - en0, n);
  endtask

  task automatic spur_idle();
    @(posedge clk); #1; spur = 1'b1;
    @(posedge clk); #1; spur = 1'b0;
  endtask

  function automatic vec_t mk(input int n, input int gap, input int stall,
                              input int w0, input int w1, input int w2, input int w3,
                              input int x0, input int x1, input int x2, input int x3,
                              input longint e32, input longint e16, input bit es16);
    vec_t v;
    v.n = n; v.gap = gap; v.stall = stall;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.e32 = e32; v.e16 = e16; v.es16 = es16;
    return v;
  endfunction

  // ---------------- main sequence -------------------------------------------
  initial begin
    vec_t   tbl [8];
    bit     c;
    bit     seen;
    longint e32, e16;
    int     n;

    tbl[0] = mk(4, 0, 0,  1, 3, -5, 7,  2, 4, 6, -8,  -72, -72, 1'b0);
    tbl[1] = mk(4, 1, 0,  1, 3, -5, 7,  2, 4, 6, -8,  -72, -72, 1'b0);
    tbl[2] = mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1'b0);
    tbl[3] = mk(4, 0, 10, 1, 3, -5, 7,  2, 4, 6, -8,  -72, -72, 1'b0);
    tbl[4] = mk(4, 0, 0,  -128, -128, -128, -128,  -128, -128, -128, -128,
                65536, SAT ? 32767 : 0, SAT);
    tbl[5] = mk(1, 0, 0,  3, 0, 0, 0,   -3, 0, 0, 0,  -9, -9, 1'b0);
    tbl[6] = mk(3, 1, 2,  127, -128, 1, 0,  127, 127, 1, 0,  -126, -126, 1'b0);
    tbl[7] = mk(2, 0, 1,  -128, -128, 0, 0,  -128, -128, 0, 0,
                32768, SAT ? 32767 : -32768, SAT);

    reset = 1'b1; start = 1'b0; len = '0; in_w = '0; in_x = '0;
    in_valid = 1'b0; res_ready = 1'b0; spur = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(outs_zero(), "reset_outputs", 0, 1);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk(outs_zero(), "post_reset_idle", 0, 1);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        pw[k] = 8'(tbl[i].w[k]);
        px[k] = 8'(tbl[i].x[k]);
      end
      spur_idle();
      run_job($sformatf("vec%0d", i), tbl[i].n, tbl[i].gap, tbl[i].stall,
              tbl[i].e32, tbl[i].e16, tbl[i].es16);
    end

    // Reset while a len=8 job is draining: job abandoned, no result.
    @(posedge clk); #1; start = 1'b1; len = 10'd8;
    @(posedge clk); #1; start = 1'b0; len = '0;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; in_w = 8'($urandom); in_x = 8'($urandom);
      @(negedge clk);
      chk(in_ready == 2'b11, "reset_job_in_ready", in_ready, 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk(outs_zero(), "reset_in_drain_outputs", 0, 1);
    @(posedge clk); #1; reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid != 2'b00 || busy != 2'b00) seen = 1'b1;
    end
    chk(!seen, "reset_in_drain_no_result", seen, 0);
    pw[0] = 8'd3; px[0] = 8'hFD;
    run_job("after_reset", 1, 0, 0, -9, -9, 1'b0);

    // Randomized jobs against the arithmetic model.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        if (r % 3 == 2) begin
          pw[k] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
          px[k] = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'h80;
        end else begin
          pw[k] = 8'($urandom);
          px[k] = 8'($urandom);
        end
      end
      e32 = model(n, 32, 1'b0, c);
      e16 = model(n, 16, SAT, c);
      run_job($sformatf("rand%0d", r), n, (r % 4 == 0) ? 0 : 2,
              $urandom_range(0, 3), e32, e16, SAT && c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Sequences one Best_MAC int8 MAC instance through a signed dot product of programmable length.
- Accepts (weight, input) pairs on a valid/ready stream and drives the MAC double-buffered weight strobes with the correct pipeline skew.
- Sums the MAC products in a wide accumulator and returns one result per job on a valid/ready result port.
- Sits between the tile scheduler and a single MAC lane, with the MAC built as LAST_SUM_W=0.

Parameters:
- DATA_W, 8: width of the signed weight and input operands.
- ACC_W, 16: width of the MAC product port (2*DATA_W).
- SUM_W, 32: width of the result accumulator; must be at least ACC_W.
- LEN_W, 10: width of the job length; maximum length is 2^LEN_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  job start pulse, sampled only in IDLE
- len  in  LEN_W  number of pairs in the job, sampled with start
- busy  out  1  high whenever state is not IDLE
- in_w  in  DATA_W  weight operand
- in_x  in  DATA_W  input operand
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid and in_ready are both high
- mac_weight_in  out  DATA_W  to MAC weight_in
- mac_preload  out  1  to MAC preload_weight
- mac_load  out  1  to MAC load_weight
- mac_enable  out  1  to MAC enable
- mac_input_val  out  DATA_W  to MAC input_val
- mac_out  in  ACC_W  from MAC mac_out, signed
- mac_out_valid  in  1  from MAC out_valid
- res_data  out  SUM_W  dot-product result, signed
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_sat  out  1  saturation flag; see Optional Feature

Behaviour:
- Reset: every output is 0, state is IDLE, all counters and the accumulator are 0. Reset mid-job abandons the job and sends no result.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start with len>0: latch len, clear accumulator, issue count and result count, then go to RUN.
  - On start with len==0: go to DONE with res_data=0.
- RUN: in_ready = 1 while issue count < len.
  - Pair accepted at cycle t: mac_preload=1 and mac_weight_in=in_w at t.
  - mac_load=1 at t+1.
  - mac_enable=1 and mac_input_val=in_x at t+2, via a 2-deep delay line of x and valid.
  - Back-to-back acceptance is fully pipelined: one pair per cycle, no bubbles.
  - Idle cycles on the input stream produce no strobes.
  - When the last pair is accepted, in_ready drops the next cycle and the state goes to DRAIN.
- Strobes are 0 in every cycle with no associated accepted pair.
- Accumulate: on each mac_out_valid while state is RUN or DRAIN, acc += sign-extended mac_out to SUM_W, and the result count increments.
  - mac_out_valid in IDLE or DONE is ignored.
- MAC latency: mac_out_valid for the pair accepted at t arrives at t+5.
- DRAIN: when the result count reaches len, with the final add in that cycle, go to DONE next cycle.
- DONE: res_valid=1 and res_data=acc, both held stable until res_ready.
  - The handshake cycle returns the FSM to IDLE; res_valid is 0 the next cycle.
  - A start in the same cycle as the handshake is ignored.
- start while busy is ignored.
- Arithmetic: two's complement throughout; wraps modulo 2^SUM_W unless MAC_SEQ_SAT_EN is defined.
- Latency: a len=N job whose pairs are accepted on consecutive cycles starting at t has res_valid high at t+N+5.

Optional Feature:
- Macro: MAC_SEQ_SAT_EN.
- Defined:
  - Each accumulate saturates to [-2^(SUM_W-1), 2^(SUM_W-1)-1].
  - res_sat is set sticky on any clamp during the job, cleared at job start, and presented with res_valid.
- Undefined:
  - Accumulation wraps.
  - res_sat is constant 0.

Test Plan:
- len=4, pairs (1,2),(3,4),(-5,6),(7,-8) on consecutive cycles from t -> res_valid at t+9, res_data=-72; mac_load pulses t+1..t+4; mac_enable pulses t+2..t+5.
- Same job with in_valid low on alternate cycles -> res_data=-72; strobe gaps mirror the input gaps; no extra mac_enable.
- start with len=0 -> res_valid the cycle after start, res_data=0, and the MAC strobes never assert.
- res_ready held low for 10 cycles in DONE -> res_valid and res_data stable; start pulses during the stall are ignored; completes on res_ready=1.
- Reset asserted during DRAIN of a len=8 job -> all outputs 0 next cycle; a following len=1 job (3,-3) returns -9.
- SUM_W=16, len=4, pairs all (-128,-128):
  - With MAC_SEQ_SAT_EN -> res_data=32767, res_sat=1.
  - Without MAC_SEQ_SAT_EN -> res_data=0, res_sat=0.
